func_param: RTL
===============

# func_param

Parametrised iterative evaluator of y = sqrt(a + cbrt(b)) for unsigned W-bit operands, with self-contained bit-serial cube-root and square-root engines and a start/busy/valid handshake. It is the next generation of the fixed 8-bit func datapath. Width is generic, both operands are latched at accept, and latency is fixed. It sits behind a register-mapped control front end that pulses start and collects the result on valid.

## Interface
- W, default 8: operand width, legal range 2..30.
- CW, derived (W+2)/3 (integer division): cube-root result width and cube-root iteration count.
- OW, derived (W+2)/2 (integer division): output width and square-root iteration count.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- a_bi  input  W  operand a, unsigned.
- b_bi  input  W  operand b, unsigned.
- start_i  input  1  request; sampled only when idle.
- busy_o  output  1  high while a computation is in flight (state != IDLE).
- valid_o  output  1  one-cycle pulse; y_bo is new in that cycle.
- y_bo  output  OW  result; holds its value until the next completion.

## Operation
- States: IDLE, CBRT, SUM, SQRT.
- IDLE:
  - If start_i=1, latch a_bi and b_bi and clear the engines' accumulators, then go to CBRT.
  - Otherwise stay in IDLE.
- CBRT: restoring integer cube root of latched b.
  - Processes 3 bits per cycle, MSB group first, for exactly CW cycles.
  - Result c = floor(cbrt(b)), CW bits.
- SUM: one cycle; s = a + c, computed at W+1 bits with no overflow possible.
- SQRT: restoring integer square root of s.
  - Processes 2 bits per cycle for exactly OW cycles.
  - r = floor(sqrt(s)), with remainder s - r².
- On the final SQRT cycle:
  - y_bo <= r (or the rounded value, see Configuration).
  - valid_o <= 1 for that one cycle.
  - State returns to IDLE.
- start_i is ignored while busy_o=1; a_bi and b_bi may change freely after the accept edge.
- start_i=1 in the cycle where valid_o=1 (state is already IDLE) is accepted, giving back-to-back operation with no gap.
- Arithmetic is unsigned throughout. The maximum result, floor(sqrt(2^W - 1 + 2^CW - 1)), always fits in OW bits.

## Timing
- Reset (rst_i=0, asynchronous):
  - busy_o=0, valid_o=0, y_bo=0, state=IDLE.
  - All internal registers are cleared.
- Reset mid-operation aborts the computation. No valid_o pulse follows, and the next start after rst_i returns high behaves normally.
- Accept edge E0: busy_o goes high in the following cycle.
- valid_o rises on edge E0 + L, where L = CW + OW + 1. Examples: W=8 gives L=9; W=16 gives L=16.
- busy_o falls on the same edge that raises valid_o.
- valid_o is never high for two consecutive cycles without a second accepted start.

## Configuration
- FUNC_PARAM_ROUND_EN defined:
  - Square-root output is rounded to nearest: y = r + 1 when (s - r²) > r, else r. This never exceeds OW bits.
  - Cube root stays floored.
  - Latency is unchanged.
- FUNC_PARAM_ROUND_EN undefined: y = floor(sqrt(a + floor(cbrt(b)))).

## Test plan
- W=8, a=0, b=0, start pulse -> valid_o exactly 9 edges after accept, y_bo=0, busy_o high for 9 cycles.
- W=8, a=20, b=64 -> cbrt 4, sum 24. y_bo=4 without FUNC_PARAM_ROUND_EN, y_bo=5 with it.
- W=8, a=255, b=255 -> cbrt 6, sum 261, y_bo=16 in both configurations. Hold start_i high and toggle a_bi/b_bi during busy -> no restart, result unchanged.
- W=8, start with a=10, b=8, then rst_i=0 for one cycle at edge E0+4 -> busy_o, valid_o, y_bo all 0 immediately. No later valid pulse. A fresh start with a=13, b=0 yields y_bo=3 (floor) or 4 (round).
- W=8, back-to-back: second start (a=99, b=1) held during the first valid cycle (a=48, b=1) -> y_bo=7 then y_bo=10, with valid pulses exactly 9 edges apart.
- W=16, a=65535, b=65535 -> cbrt 40, sum 65575, y_bo=256 (9 bits), valid_o 16 edges after accept.

Source files
------------

// File: rtl/func_param_if.sv
// Start/busy/valid handshake bundle for func_param: operands in, result out.
interface func_param_if #(
   parameter int W = 8
);
   localparam int OW = (W + 2) / 2;

   logic [W-1:0]  a_bi;
   logic [W-1:0]  b_bi;
   logic          start_i;
   logic          busy_o;
   logic          valid_o;
   logic [OW-1:0] y_bo;

   modport master (
      output a_bi, b_bi, start_i,
      input  busy_o, valid_o, y_bo
   );

   modport slave (
      input  a_bi, b_bi, start_i,
      output busy_o, valid_o, y_bo
   );
endinterface

// File: rtl/func_param.sv
// Iterative y = sqrt(a + cbrt(b)) for unsigned W-bit operands, bit-serial engines.
// Optional FUNC_PARAM_ROUND_EN: round the square root to nearest instead of flooring.
module func_param #(
   parameter int W = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   func_param_if.slave bus
);
   localparam int CW   = (W + 2) / 3;
   localparam int OW   = (W + 2) / 2;
   localparam int BW   = 3 * CW;
   localparam int CRW  = 2 * CW + 6;
   localparam int SW   = 2 * OW;
   localparam int SRW  = OW + 4;
   localparam int SUMW = W + 1;
   localparam int NW   = $clog2(OW + 1);

   typedef enum logic [1:0] {IDLE, CBRT, SUM, SQRT} state_t;

   state_t         state, state_nx;
   logic [NW-1:0]  cnt;
   logic [W-1:0]   a_q;
   logic [BW-1:0]  b_sh;
   logic [CRW-1:0] c_rem;
   logic [CW-1:0]  c_acc;
   logic [SW-1:0]  s_sh;
   logic [SRW-1:0] s_rem;
   logic [OW-1:0]  s_acc;
   logic           valid_q;
   logic [OW-1:0]  y_q;

   logic [CRW-1:0] c_rem_sh, c_y2, c_cand, c_rem_nx;
   logic [CW-1:0]  c_acc_nx;
   logic           c_ge;
   logic [SRW-1:0] s_rem_sh, s_cand, s_rem_nx;
   logic [OW-1:0]  s_acc_nx, y_fin;
   logic           s_ge;
   logic [SUMW-1:0] sum;

   // Both roots keep a running remainder and shift the next digit group in,
   // so each step only compares against the candidate (2y+1)^k - (2y)^k.
   always_comb begin
      c_rem_sh = (c_rem << 3) | CRW'(b_sh[BW-1 -: 3]);
      c_y2     = CRW'(c_acc) << 1;
      c_cand   = CRW'(3) * c_y2 * (c_y2 + CRW'(1)) + CRW'(1);
      c_ge     = (c_rem_sh >= c_cand);
      c_rem_nx = c_ge ? (c_rem_sh - c_cand) : c_rem_sh;
      c_acc_nx = (c_acc << 1) | CW'(c_ge);

      s_rem_sh = (s_rem << 2) | SRW'(s_sh[SW-1 -: 2]);
      s_cand   = (SRW'(s_acc) << 2) | SRW'(1);
      s_ge     = (s_rem_sh >= s_cand);
      s_rem_nx = s_ge ? (s_rem_sh - s_cand) : s_rem_sh;
      s_acc_nx = (s_acc << 1) | OW'(s_ge);

      y_fin = s_acc_nx;
`ifdef FUNC_PARAM_ROUND_EN
      if (s_rem_nx > SRW'(s_acc_nx)) y_fin = s_acc_nx + OW'(1);
`endif
      sum = SUMW'(a_q) + SUMW'(c_acc);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start_i) state_nx = CBRT;
         CBRT:    if (cnt == '0) state_nx = SUM;
         SUM:     state_nx = SQRT;
         SQRT:    if (cnt == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt     <= '0;
         a_q     <= '0;
         b_sh    <= '0;
         c_rem   <= '0;
         c_acc   <= '0;
         s_sh    <= '0;
         s_rem   <= '0;
         s_acc   <= '0;
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  a_q   <= bus.a_bi;
                  b_sh  <= BW'(bus.b_bi);
                  c_rem <= '0;
                  c_acc <= '0;
                  s_sh  <= '0;
                  s_rem <= '0;
                  s_acc <= '0;
                  cnt   <= NW'(CW - 1);
               end
            end
            CBRT: begin
               b_sh  <= b_sh << 3;
               c_rem <= c_rem_nx;
               c_acc <= c_acc_nx;
               cnt   <= cnt - NW'(1);
            end
            SUM: begin
               s_sh <= SW'(sum);
               cnt  <= NW'(OW - 1);
            end
            SQRT: begin
               s_sh  <= s_sh << 2;
               s_rem <= s_rem_nx;
               s_acc <= s_acc_nx;
               if (cnt == '0) begin
                  y_q     <= y_fin;
                  valid_q <= 1'b1;
               end else begin
                  cnt <= cnt - NW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o  = (state != IDLE);
   assign bus.valid_o = valid_q;
   assign bus.y_bo    = y_q;
endmodule
